axil_arbiter_rr_rd: RTL



---
 rtl/axil_arbiter_rr_rd.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin AXI-Lite read arbiter: one grant per AR+R transaction, registered grant 1 cycle after request.
// Grant is held through AR/R stalls until completion, watchdog expiry or reset; idle cycle between grants.
module axil_arbiter_rr_rd #(
  parameter int NUMBER_MASTER  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUMBER_MASTER-1:0]         request_rd,
  output logic [NUMBER_MASTER-1:0]         grant_rd,
  output logic [$clog2(NUMBER_MASTER)-1:0] grant_rd_cdr,
  input  logic [NUMBER_MASTER-1:0]         m_axil_arvalid,
  input  logic                             s_axil_arready,
  input  logic                             s_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0]         m_axil_rready,
  output logic                             busy,
  output logic                             timeout
);
  localparam int IDX_W = $clog2(NUMBER_MASTER);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                   state, state_nxt;
  logic [NUMBER_MASTER-1:0] grant_nxt;
  logic [IDX_W-1:0]         cdr_nxt;
  logic [IDX_W-1:0]         last, last_nxt;
  logic [IDX_W-1:0]         winner;
  logic                     busy_nxt, timeout_nxt;
  logic                     found, ar_hs, r_hs, expire;
  int                       idx;

  assign ar_hs = m_axil_arvalid[grant_rd_cdr] && s_axil_arready;
  assign r_hs  = s_axil_rvalid && m_axil_rready[grant_rd_cdr];

  // Cyclic scan starting just after the last winner; last itself is checked last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUMBER_MASTER; i++) begin
      idx = (int'(last) + i) % NUMBER_MASTER;
      if (!found && request_rd[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      logic [CNT_W-1:0] cnt;

      // Saturates at CNT_LAST; the FSM always leaves the grant on that cycle anyway.
      always_ff @(posedge aclk) begin
        if (areset || state == IDLE) cnt <= '0;
        else if (cnt != CNT_LAST)    cnt <= cnt + 1'b1;
      end

      assign expire = (state != IDLE) && (cnt == CNT_LAST);
    end else begin : g_no_wdog
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_rd;
    cdr_nxt     = grant_rd_cdr;
    last_nxt    = last;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = ADDR;
          grant_nxt = NUMBER_MASTER'(1) << winner;
          cdr_nxt   = winner;
          last_nxt  = winner;
          busy_nxt  = 1'b1;
        end
      end
      ADDR: begin
        // Only the R handshake completes a transaction, so expiry in ADDR always revokes.
        if (expire) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          cdr_nxt     = '0;
          busy_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end else if (ar_hs) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (r_hs || expire) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          cdr_nxt     = '0;
          busy_nxt    = 1'b0;
          timeout_nxt = !r_hs;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cdr_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      grant_rd     <= '0;
      grant_rd_cdr <= '0;
      last         <= IDX_W'(NUMBER_MASTER - 1);
      busy         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant_rd     <= grant_nxt;
      grant_rd_cdr <= cdr_nxt;
      last         <= last_nxt;
      busy         <= busy_nxt;
      timeout      <= timeout_nxt;
    end
  end

endmodule
